// File: rtl/axi_stream_output_if.sv
// AXI4-Stream bundle used on the NPU result drain path.
// The master drives payload and valid; the slave returns ready.
interface axi_stream_output_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 33
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tdata, tstrb, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axi_stream_output.sv
// Drains row*col words from an SRAM bank onto an AXI4-Stream master.
// Sync-SRAM reads feed a 2-entry skid FIFO so tready stalls never drop data.
module axi_stream_output #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64+1)
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_areset,
  input  logic                          start,
  input  logic [2:0]                    src_sel,
  input  logic [ADDR_WIDTH-1:0]         out_row,
  input  logic [ADDR_WIDTH-1:0]         out_col,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          read_enable,
  output logic [2:0]                    read_sram_sel,
  output logic [ADDR_WIDTH-1:0]         read_address,
  input  logic [DATA_WIDTH-1:0]         read_data,
  axi_stream_output_if.master           m_axis,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = 2 * ADDR_WIDTH;
  localparam int UW = 2 * ADDR_WIDTH + NUM_CHANNELS_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         total;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         beat_cnt;
  logic [UW-1:0]         user_q;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic [1:0]            fifo_cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  inflight;
  logic [PW-1:0]         product;
  logic                  len_ok;
  logic                  pop;
  logic                  push;
  logic [2:0]            occ;

  assign product = PW'(out_row) * PW'(out_col);
  assign len_ok  = (product != '0) &&
                   (product <= (PW'(1) << ADDR_WIDTH));

  assign pop  = m_axis.tvalid && m_axis.tready;
  assign push = inflight;

  // Occupancy the FIFO will have once the outstanding read lands.
  assign occ = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

  assign read_enable  = (state == RUN) && (rd_cnt < total) &&
                        (occ < 3'd2);
  assign read_address = rd_cnt[ADDR_WIDTH-1:0];

  assign m_axis.tvalid = (fifo_cnt != 2'd0);
  assign m_axis.tdata  = fifo[rd_ptr];
  assign m_axis.tlast  = m_axis.tvalid &&
                         (beat_cnt == total - CW'(1));
  assign m_axis.tuser  = user_q;
  assign m_axis.tstrb  = {(DATA_WIDTH/8){m_axis.tvalid}};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state         <= IDLE;
      total         <= '0;
      rd_cnt        <= '0;
      beat_cnt      <= '0;
      user_q        <= '0;
      fifo[0]       <= '0;
      fifo[1]       <= '0;
      fifo_cnt      <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      inflight      <= 1'b0;
      read_sram_sel <= 3'd0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err  <= 1'b0;
      inflight <= read_enable;
      if (read_enable) rd_cnt <= rd_cnt + CW'(1);
      if (push) begin
        fifo[wr_ptr] <= read_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + CW'(1);
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      unique case (state)
        IDLE: begin
          if (start && len_ok) begin
            state         <= RUN;
            total         <= product[CW-1:0];
            rd_cnt        <= '0;
            beat_cnt      <= '0;
            read_sram_sel <= src_sel;
            user_q        <= {out_row, out_col, num_channels};
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        RUN:     if (pop && m_axis.tlast) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_stream_output.sv
// Randomised scoreboard bench for axi_stream_output.
// Driver queues expected reads/beats; a negedge monitor pops and compares.
module tb_axi_stream_output;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int CHW = 7;
  localparam int UW  = 2 * AW + CHW;
  localparam int MAXLEN = 2 ** AW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     src_sel;
  logic [AW-1:0]  out_row;
  logic [AW-1:0]  out_col;
  logic [CHW-1:0] num_channels;
  logic           read_enable;
  logic [2:0]     read_sram_sel;
  logic [AW-1:0]  read_address;
  logic [DW-1:0]  read_data = '0;
  logic           busy;
  logic           done;
  logic           cfg_err;

  axi_stream_output_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) axis ();

  axi_stream_output #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHANNELS_WIDTH(CHW)
  ) dut (
    .m_axis_aclk(clk),
    .m_axis_areset(rst),
    .start(start),
    .src_sel(src_sel),
    .out_row(out_row),
    .out_col(out_col),
    .num_channels(num_channels),
    .read_enable(read_enable),
    .read_sram_sel(read_sram_sel),
    .read_address(read_address),
    .read_data(read_data),
    .m_axis(axis),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MAXLEN];

  function automatic logic [DW-1:0] word(input logic [2:0] s,
                                         input int a);
    return mem[a] ^ {s, 5'b0};
  endfunction

  // Synchronous SRAM: data one cycle after the strobe.
  always @(posedge clk)
    if (read_enable)
      read_data <= word(read_sram_sel, int'(read_address));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input bit ok, input string nm,
                       input longint act, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  beat_t      beat_q[$];
  int         addr_q[$];
  logic [2:0] exp_sel = '0;
  bit         active = 0;
  bit         first_seen = 1;
  int         start_cyc = 0;
  int         busy_from = 0;
  int         exp_done_cyc = -100;
  int         bad_cyc = -100;
  int         last_done_cyc = -1;
  int         n_hs = 0;
  int         n_re = 0;
  int         n_cfg = 0;
  int         rmode = 0;

  bit            prev_stall = 0;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  logic [UW-1:0] prev_u;

  always @(negedge clk) begin
    if (!rst) begin
      beat_t e;
      bit    eb;
      check(axis.tstrb == {(DW/8){axis.tvalid}}, "tstrb",
            axis.tstrb, {(DW/8){axis.tvalid}});
      if (prev_stall)
        check(axis.tvalid && axis.tdata == prev_d &&
              axis.tlast == prev_l && axis.tuser == prev_u,
              "stall_hold", axis.tdata, prev_d);
      if (axis.tvalid && active && !first_seen) begin
        check(cyc == start_cyc + 3, "first_valid_cycle",
              cyc - start_cyc, 3);
        first_seen = 1;
      end
      if (axis.tvalid && axis.tready) begin
        if (beat_q.size() == 0) begin
          check(0, "extra_beat", axis.tdata, 0);
        end else begin
          e = beat_q.pop_front();
          check(axis.tdata == e.d, "tdata", axis.tdata, e.d);
          check(axis.tlast == e.l, "tlast", axis.tlast, e.l);
          check(axis.tuser == e.u, "tuser", axis.tuser, e.u);
          n_hs++;
          if (e.l) exp_done_cyc = cyc + 1;
        end
      end
      if (done || cyc == exp_done_cyc) begin
        check(done && cyc == exp_done_cyc, "done",
              done, cyc == exp_done_cyc);
        if (done) last_done_cyc = cyc;
      end
      eb = active && cyc >= busy_from && cyc != exp_done_cyc;
      check(busy == eb, "busy", busy, eb);
      if (cyc == exp_done_cyc) active = 0;
      if (cfg_err || cyc == bad_cyc + 1) begin
        check(cfg_err && cyc == bad_cyc + 1, "cfg_err",
              cfg_err, cyc == bad_cyc + 1);
        if (cfg_err) n_cfg++;
      end
      if (read_enable) begin
        n_re++;
        if (addr_q.size() == 0) begin
          check(0, "extra_read", read_address, 0);
        end else begin
          int a;
          a = addr_q.pop_front();
          check(int'(read_address) == a, "rd_addr", read_address, a);
          check(read_sram_sel == exp_sel, "rd_sel",
                read_sram_sel, exp_sel);
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_d     = axis.tdata;
      prev_l     = axis.tlast;
      prev_u     = axis.tuser;
    end
  end

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ~axis.tready;
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int r, input int c,
                             input int ch, input int s);
    out_row      = AW'(r);
    out_col      = AW'(c);
    num_channels = CHW'(ch);
    src_sel      = 3'(s);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic launch(input int r, input int c,
                        input int ch, input int s);
    int tot;
    logic [UW-1:0] u;
    tot = r * c;
    u   = {AW'(r), AW'(c), CHW'(ch)};
    start_cyc = cyc;
    if (tot >= 1 && tot <= MAXLEN) begin
      active       = 1;
      first_seen   = 0;
      busy_from    = cyc + 1;
      exp_done_cyc = -100;
      exp_sel      = 3'(s);
      n_hs         = 0;
      for (int i = 0; i < tot; i++) begin
        beat_t b;
        b.d = word(3'(s), i);
        b.l = (i == tot - 1);
        b.u = u;
        addr_q.push_back(i);
        beat_q.push_back(b);
      end
    end else begin
      bad_cyc = cyc;
    end
    pulse_start(r, c, ch, s);
  endtask

  task automatic flush();
    beat_q.delete();
    addr_q.delete();
    active       = 0;
    first_seen   = 1;
    exp_done_cyc = -100;
    prev_stall   = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!active && beat_q.size() == 0 && cyc > bad_cyc + 1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check(0, "timeout", beat_q.size(), 0);
      flush();
    end else begin
      check(addr_q.size() == 0, "reads_left", addr_q.size(), 0);
    end
  endtask

  task automatic check_zero();
    check(!axis.tvalid && !axis.tlast && !read_enable &&
          !busy && !done && !cfg_err, "rst_ctrl",
          {axis.tvalid, axis.tlast, read_enable, busy, done, cfg_err},
          0);
    check(axis.tdata == '0 && axis.tuser == '0 &&
          read_address == '0 && read_sram_sel == '0 &&
          axis.tstrb == '0, "rst_data",
          axis.tuser ^ axis.tdata ^ read_address, 0);
  endtask

  initial begin
    int t1;
    int snap;
    rst          = 1'b1;
    start        = 1'b0;
    src_sel      = '0;
    out_row      = '0;
    out_col      = '0;
    num_channels = '0;
    for (int i = 0; i < MAXLEN; i++) mem[i] = DW'(i);
    @(negedge clk);
    check_zero();
    tick();
    tick();
    rst = 1'b0;
    tick();

    rmode = 0;
    t1 = cyc;
    launch(2, 3, 4, 0);
    wait_idle(100);
    check(last_done_cyc == t1 + 9, "done_cycle",
          last_done_cyc - t1, 9);

    rmode = 1;
    launch(2, 3, 4, 0);
    wait_idle(100);

    rmode = 0;
    launch(1, 1, 9, 1);
    wait_idle(100);

    snap = n_re;
    launch(0, 5, 1, 2);
    wait_idle(20);
    launch(129, 129, 1, 2);
    wait_idle(20);
    launch(3, 2731, 1, 2);
    wait_idle(20);
    check(n_cfg == 3, "cfg_err_count", n_cfg, 3);
    check(n_re == snap, "bad_no_reads", n_re - snap, 0);

    for (int i = 0; i < MAXLEN; i++) mem[i] = DW'($urandom);
    rmode = 2;
    launch(64, 128, 5, 3);
    wait_idle(40000);

    launch(3, 4, 7, 4);
    repeat (5) tick();
    pulse_start(7, 7, 1, 6);
    wait_idle(200);

    rmode = 0;
    launch(2, 3, 4, 5);
    for (int i = 0; i < 100 && n_hs < 3; i++) tick();
    check(n_hs >= 3, "reach_beat3", n_hs, 3);
    rst = 1'b1;
    flush();
    @(negedge clk);
    check_zero();
    tick();
    rst = 1'b0;
    tick();
    launch(1, 2, 3, 5);
    wait_idle(100);
    check(n_hs == 2, "restart_beats", n_hs, 2);

    for (int k = 0; k < 15; k++) begin
      for (int j = 0; j < 64; j++) mem[j] = DW'($urandom);
      rmode = int'($urandom_range(0, 2));
      launch(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
             int'($urandom_range(0, 64)), int'($urandom_range(0, 7)));
      wait_idle(400);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
